muntjac_fpu_normalize_pipe: RTL and testbench

Pipelined, flow-controlled leading-zero normalizer for FPU mantissa post-processing. It left-shifts a mantissa until the MSB is set, but the shift never exceeds a per-operation limit. The limit lets subnormal results stop at the minimum exponent. The block spreads the log-shifter levels over NumStages registered stages, uses valid/ready handshakes on both sides, and carries a sideband tag through with each operation.

---
 rtl/muntjac_fpu_normalize_pipe.sv | 174 +++++++++++++++++
 tb/tb_muntjac_fpu_normalize_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muntjac_fpu_normalize_pipe.sv
// Pipelined leading-zero normalizer with a per-operation shift cap.
// Shifts the mantissa left until its MSB is set, but never by more than
// limit_i, so subnormal results can stop at the minimum exponent. The
// log-shifter levels are spread over NumStages registered stages with a
// valid/ready handshake between every stage and a sideband tag riding along.
module muntjac_fpu_normalize_pipe #(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumStages  = 2,
    parameter int unsigned TagWidth   = 1,
    localparam int unsigned ShiftWidth = $clog2(DataWidth)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  data_i,
    input  logic [ShiftWidth-1:0] limit_i,
    input  logic [TagWidth-1:0]   tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  data_o,
    output logic [ShiftWidth-1:0] shift_o,
    output logic                  is_zero_o,
    output logic                  limited_o,
    output logic [TagWidth-1:0]   tag_o
);

    // Higher shifter levels go to earlier stages; the last stage absorbs any
    // remainder, and surplus stages (when levels run out) just pass data on.
    localparam int unsigned LevelsPerStage = (ShiftWidth + NumStages - 1) / NumStages;

    function automatic int level_stage(input int level);
        int stg;
        stg = (int'(ShiftWidth) - 1 - level) / int'(LevelsPerStage);
        if (stg > int'(NumStages) - 1) stg = int'(NumStages) - 1;
        return stg;
    endfunction

    // Stage registers
    logic [NumStages-1:0]  vld_q, vld_d;
    logic [NumStages-1:0]  zero_q, zero_d;
    logic [DataWidth-1:0]  data_q  [NumStages];
    logic [DataWidth-1:0]  data_d  [NumStages];
    logic [ShiftWidth-1:0] shift_q [NumStages];
    logic [ShiftWidth-1:0] shift_d [NumStages];
    logic [ShiftWidth-1:0] limit_q [NumStages];
    logic [ShiftWidth-1:0] limit_d [NumStages];
    logic [TagWidth-1:0]   tag_q   [NumStages];
    logic [TagWidth-1:0]   tag_d   [NumStages];
    logic                  limited_q, limited_d;

    // Values presented to each stage by its upstream neighbour
    logic [NumStages-1:0]  up_vld;
    logic [NumStages-1:0]  up_zero;
    logic [DataWidth-1:0]  up_data  [NumStages];
    logic [ShiftWidth-1:0] up_shift [NumStages];
    logic [ShiftWidth-1:0] up_limit [NumStages];
    logic [TagWidth-1:0]   up_tag   [NumStages];

    logic [NumStages-1:0]  stage_ready;

    // Working values of the log shifter while walking one stage's levels
    logic [DataWidth-1:0]  cur;
    logic [ShiftWidth-1:0] acc;

    // Stage 0 is fed from the input port; later stages from the previous register.
    always_comb begin
        up_vld[0]   = in_valid_i;
        up_zero[0]  = (data_i == '0);
        up_data[0]  = data_i;
        up_shift[0] = '0;
        up_limit[0] = limit_i;
        up_tag[0]   = tag_i;
        for (int s = 1; s < int'(NumStages); s++) begin
            up_vld[s]   = vld_q[s-1];
            up_zero[s]  = zero_q[s-1];
            up_data[s]  = data_q[s-1];
            up_shift[s] = shift_q[s-1];
            up_limit[s] = limit_q[s-1];
            up_tag[s]   = tag_q[s-1];
        end
    end

    // A stage can accept if it, or any stage after it, has a hole, or the
    // consumer drains the tail this cycle; this is what collapses bubbles.
    always_comb begin
        for (int s = 0; s < int'(NumStages); s++) begin
            stage_ready[s] = out_ready_i;
            for (int t = s; t < int'(NumStages); t++) begin
                if (!vld_q[t]) stage_ready[s] = 1'b1;
            end
        end
    end

    // Per-stage shifter levels and register load/hold decisions.
    always_comb begin
        vld_d     = vld_q;
        zero_d    = zero_q;
        data_d    = data_q;
        shift_d   = shift_q;
        limit_d   = limit_q;
        tag_d     = tag_q;
        limited_d = limited_q;
        cur       = '0;
        acc       = '0;
        for (int s = 0; s < int'(NumStages); s++) begin
            cur = up_data[s];
            acc = up_shift[s];
            // Greedy MSB-first: take a 2^b shift only if those top bits are
            // zero and the running total stays within the limit.
            for (int b = int'(ShiftWidth) - 1; b >= 0; b--) begin
                if (level_stage(b) == s) begin
                    if (((cur >> (DataWidth - (1 << b))) == '0) &&
                        (int'(acc) + (1 << b) <= int'(up_limit[s]))) begin
                        cur = cur << (1 << b);
                        acc = acc + ShiftWidth'(1 << b);
                    end
                end
            end

            if (flush_i) begin
                vld_d[s] = 1'b0;
            end else if (stage_ready[s]) begin
                vld_d[s] = up_vld[s];
            end

            if (up_vld[s] && stage_ready[s]) begin
                data_d[s]  = cur;
                shift_d[s] = acc;
                limit_d[s] = up_limit[s];
                zero_d[s]  = up_zero[s];
                tag_d[s]   = up_tag[s];
                if (s == int'(NumStages) - 1) begin
                    limited_d = !up_zero[s] && !cur[DataWidth-1];
                end
            end
        end
    end

    // Pipeline stage boundaries: every stage register, cleared on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            zero_q    <= '0;
            limited_q <= 1'b0;
            for (int s = 0; s < int'(NumStages); s++) begin
                data_q[s]  <= '0;
                shift_q[s] <= '0;
                limit_q[s] <= '0;
                tag_q[s]   <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            zero_q    <= zero_d;
            limited_q <= limited_d;
            for (int s = 0; s < int'(NumStages); s++) begin
                data_q[s]  <= data_d[s];
                shift_q[s] <= shift_d[s];
                limit_q[s] <= limit_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

    assign in_ready_o  = stage_ready[0] || flush_i;
    assign out_valid_o = vld_q[NumStages-1];
    assign data_o      = data_q[NumStages-1];
    assign shift_o     = shift_q[NumStages-1];
    assign is_zero_o   = zero_q[NumStages-1];
    assign limited_o   = limited_q;
    assign tag_o       = tag_q[NumStages-1];

endmodule

// File: tb/tb_muntjac_fpu_normalize_pipe.sv
// Bench for the normalizer: a 16-bit/2-stage instance exercised with directed
// vectors, back-pressure, flush and reset, plus 64-bit instances with 1 and
// 4 stages fed random operands, all checked against a min(lzc, limit) model.
module tb_muntjac_fpu_normalize_pipe;

    typedef struct {
        logic [63:0] d;
        int          sh;
        bit          z;
        bit          l;
        int          tag;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_out  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: 16-bit, 2 stages, 4-bit tag
    logic        flush, in_valid, out_ready;
    logic [15:0] din;
    logic [3:0]  lim, tag;
    logic        mi_ready, mo_valid, mo_zero, mo_lim;
    logic [15:0] mo_data;
    logic [3:0]  mo_shift, mo_tag;

    muntjac_fpu_normalize_pipe #(.DataWidth(16), .NumStages(2), .TagWidth(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(mi_ready),
        .data_i(din), .limit_i(lim), .tag_i(tag),
        .out_valid_o(mo_valid), .out_ready_i(out_ready),
        .data_o(mo_data), .shift_o(mo_shift), .is_zero_o(mo_zero),
        .limited_o(mo_lim), .tag_o(mo_tag)
    );

    // Sweep instances: 64-bit, 1 and 4 stages, always ready
    logic        sv;
    logic [63:0] sdin;
    logic [5:0]  slim;
    logic [7:0]  stag;
    logic        s1_ready, s1_valid, s1_zero, s1_lim;
    logic        s4_ready, s4_valid, s4_zero, s4_lim;
    logic [63:0] s1_data, s4_data;
    logic [5:0]  s1_shift, s4_shift;
    logic [7:0]  s1_tag, s4_tag;

    muntjac_fpu_normalize_pipe #(.DataWidth(64), .NumStages(1), .TagWidth(8)) dut_s1 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .in_valid_i(sv), .in_ready_o(s1_ready),
        .data_i(sdin), .limit_i(slim), .tag_i(stag),
        .out_valid_o(s1_valid), .out_ready_i(1'b1),
        .data_o(s1_data), .shift_o(s1_shift), .is_zero_o(s1_zero),
        .limited_o(s1_lim), .tag_o(s1_tag)
    );

    muntjac_fpu_normalize_pipe #(.DataWidth(64), .NumStages(4), .TagWidth(8)) dut_s4 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .in_valid_i(sv), .in_ready_o(s4_ready),
        .data_i(sdin), .limit_i(slim), .tag_i(stag),
        .out_valid_o(s4_valid), .out_ready_i(1'b1),
        .data_o(s4_data), .shift_o(s4_shift), .is_zero_o(s4_zero),
        .limited_o(s4_lim), .tag_o(s4_tag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: shift = min(leading zeros within w bits, limit).
    function automatic exp_t model(input logic [63:0] d, input int w, input int limv);
        exp_t        e;
        int          lz;
        logic [63:0] mask;
        lz = w;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) begin
                lz = w - 1 - i;
                break;
            end
        end
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        e.sh  = (lz < limv) ? lz : limv;
        e.d   = (d << e.sh) & mask;
        e.z   = (d == 64'd0);
        e.l   = !e.z && !e.d[w-1];
        e.tag = 0;
        e.due = 0;
        return e;
    endfunction

    // Scoreboard for the main instance: in-order, stable while stalled.
    exp_t        q_main[$];
    exp_t        em;
    bit          hold = 1'b0;
    logic [15:0] hd;
    logic [3:0]  hs, ht;
    always @(negedge clk) begin
        if (rst) begin
            q_main.delete();
            hold = 1'b0;
            chk("rst_out_valid", 64'(mo_valid), 64'd0);
            chk("rst_data",      64'(mo_data),  64'd0);
            chk("rst_shift",     64'(mo_shift), 64'd0);
            chk("rst_flags",     64'({mo_zero, mo_lim}), 64'd0);
            chk("rst_tag",       64'(mo_tag),   64'd0);
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(mo_valid), 64'd1);
                chk("hold_data",  64'(mo_data),  64'(hd));
                chk("hold_shift", 64'(mo_shift), 64'(hs));
                chk("hold_tag",   64'(mo_tag),   64'(ht));
            end
            if (mo_valid) begin
                if (q_main.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main_unexpected: got out_valid=1 tag=%0d expected no output", mo_tag);
                end else begin
                    em = q_main[0];
                    chk("main_data",    64'(mo_data),  em.d);
                    chk("main_shift",   64'(mo_shift), 64'(em.sh));
                    chk("main_zero",    64'(mo_zero),  64'(em.z));
                    chk("main_limited", 64'(mo_lim),   64'(em.l));
                    chk("main_tag",     64'(mo_tag),   64'(em.tag));
                    if (out_ready) begin
                        q_main.delete(0);
                        n_out++;
                    end
                end
            end
            hold = mo_valid && !out_ready && !flush;
            hd = mo_data;
            hs = mo_shift;
            ht = mo_tag;
            if (flush) begin
                q_main.delete();
            end else if (in_valid && mi_ready) begin
                em = model(64'(din), 16, int'(lim));
                em.tag = int'(tag);
                q_main.push_back(em);
            end
        end
    end

    // Scoreboard for the sweep instances: fixed latency of NumStages.
    exp_t q1[$], q4[$];
    exp_t e1, e4, es;
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q4.delete();
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e1 = q1[0];
                q1.delete(0);
                chk("s1_valid", 64'(s1_valid), 64'd1);
                chk("s1_data",  s1_data,       e1.d);
                chk("s1_shift", 64'(s1_shift), 64'(e1.sh));
                chk("s1_flags", 64'({s1_zero, s1_lim}), 64'({e1.z, e1.l}));
                chk("s1_tag",   64'(s1_tag),   64'(e1.tag));
            end else begin
                chk("s1_idle", 64'(s1_valid), 64'd0);
            end
            if (q4.size() > 0 && q4[0].due == cyc) begin
                e4 = q4[0];
                q4.delete(0);
                chk("s4_valid", 64'(s4_valid), 64'd1);
                chk("s4_data",  s4_data,       e4.d);
                chk("s4_shift", 64'(s4_shift), 64'(e4.sh));
                chk("s4_flags", 64'({s4_zero, s4_lim}), 64'({e4.z, e4.l}));
                chk("s4_tag",   64'(s4_tag),   64'(e4.tag));
            end else begin
                chk("s4_idle", 64'(s4_valid), 64'd0);
            end
            if (sv) begin
                chk("s1_in_ready", 64'(s1_ready), 64'd1);
                chk("s4_in_ready", 64'(s4_ready), 64'd1);
                es = model(sdin, 64, int'(slim));
                es.tag = int'(stag);
                es.due = cyc + 1;
                q1.push_back(es);
                es.due = cyc + 4;
                q4.push_back(es);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation through an empty pipe with hand-computed results.
    task automatic single(input logic [15:0] d, input logic [3:0] l, input logic [3:0] t,
                          input logic [15:0] ed, input int esh, input bit ez, input bit el);
        in_valid = 1'b1;
        din = d;
        lim = l;
        tag = t;
        #1;
        chk("single_in_ready", 64'(mi_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("single_lat1_idle", 64'(mo_valid), 64'd0);
        step();
        chk("single_lat2_valid", 64'(mo_valid), 64'd1);
        chk("single_data",    64'(mo_data),  64'(ed));
        chk("single_shift",   64'(mo_shift), 64'(esh));
        chk("single_zero",    64'(mo_zero),  64'(ez));
        chk("single_limited", 64'(mo_lim),   64'(el));
        chk("single_tag",     64'(mo_tag),   64'(t));
        step();
        chk("single_drained", 64'(mo_valid), 64'd0);
    endtask

    int n0;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din = '0;
        lim = '0;
        tag = '0;
        sv = 1'b0;
        sdin = '0;
        slim = '0;
        stag = '0;
        repeat (3) step();
        chk("reset_out_valid", 64'(mo_valid), 64'd0);
        chk("reset_data",      64'(mo_data),  64'd0);
        rst = 1'b0;
        step();
        chk("idle_in_ready", 64'(mi_ready), 64'd1);

        // Directed vectors
        single(16'h0013, 4'd15, 4'd1, 16'h9800, 11, 1'b0, 1'b0);
        single(16'h0013, 4'd4,  4'd2, 16'h0130, 4,  1'b0, 1'b1);
        single(16'h8001, 4'd15, 4'd3, 16'h8001, 0,  1'b0, 1'b0);
        single(16'h0000, 4'd15, 4'd4, 16'h0000, 15, 1'b1, 1'b0);
        single(16'h0000, 4'd0,  4'd5, 16'h0000, 0,  1'b1, 1'b0);
        single(16'h0013, 4'd0,  4'd6, 16'h0013, 0,  1'b0, 1'b1);
        single(16'h0001, 4'd15, 4'd7, 16'h8000, 15, 1'b0, 1'b0);

        // Back-pressure: six ops, consumer stalled for the first four cycles
        n0 = n_out;
        out_ready = 1'b0;
        in_valid = 1'b1;
        lim = 4'd15;
        din = 16'h0001; tag = 4'd1; #1;
        chk("bp_ready_op1", 64'(mi_ready), 64'd1);
        step();
        din = 16'h0004; tag = 4'd2; #1;
        chk("bp_ready_op2", 64'(mi_ready), 64'd1);
        step();
        din = 16'h0010; tag = 4'd3; #1;
        chk("bp_full_0", 64'(mi_ready), 64'd0);
        step();
        chk("bp_full_1", 64'(mi_ready), 64'd0);
        step();
        out_ready = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            din = 16'h0001 << (2 * i - 2);
            lim = (i == 5) ? 4'd3 : 4'd15;
            tag = 4'(i);
            #1;
            chk("bp_stream_ready", 64'(mi_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_count", 64'(n_out - n0), 64'd6);

        // Flush with two ops held; the op offered during the flush is dropped
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = 16'h0100; lim = 4'd15; tag = 4'd8;
        step();
        din = 16'h0200; tag = 4'd9;
        step();
        din = 16'h0400; tag = 4'd10;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(mi_ready), 64'd1);
        step();
        flush = 1'b0;
        chk("flush_cleared", 64'(mo_valid), 64'd0);
        out_ready = 1'b1;
        din = 16'h0013; lim = 4'd15; tag = 4'd11;
        step();
        in_valid = 1'b0;
        chk("post_flush_lat1", 64'(mo_valid), 64'd0);
        step();
        chk("post_flush_valid", 64'(mo_valid), 64'd1);
        chk("post_flush_tag",   64'(mo_tag),   64'd11);
        chk("post_flush_data",  64'(mo_data),  64'h9800);
        step();
        chk("post_flush_drain", 64'(mo_valid), 64'd0);

        // Asynchronous reset mid-cycle with two ops in flight
        in_valid = 1'b1;
        din = 16'h0300; lim = 4'd15; tag = 4'd12;
        step();
        din = 16'h0030; tag = 4'd13;
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(mo_valid), 64'd0);
        chk("async_rst_data",  64'(mo_data),  64'd0);
        chk("async_rst_shift", 64'(mo_shift), 64'd0);
        chk("async_rst_tag",   64'(mo_tag),   64'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        din = 16'h0013; lim = 4'd4; tag = 4'd14;
        step();
        in_valid = 1'b0;
        chk("post_rst_lat1", 64'(mo_valid), 64'd0);
        step();
        chk("post_rst_valid", 64'(mo_valid), 64'd1);
        chk("post_rst_data",  64'(mo_data),  64'h0130);
        chk("post_rst_lim",   64'(mo_lim),   64'd1);
        step();

        // Random sweep on the 64-bit instances
        for (int i = 0; i < 300; i++) begin
            sv   = ($urandom_range(0, 3) != 0);
            sdin = {$urandom, $urandom} >> $urandom_range(0, 64);
            slim = 6'($urandom_range(0, 63));
            if (i % 37 == 0) slim = 6'd0;
            if (i % 41 == 0) sdin = 64'd0;
            stag = 8'($urandom);
            step();
        end
        sv = 1'b0;
        repeat (6) step();

        chk("main_queue_empty", 64'(q_main.size()), 64'd0);
        chk("s1_queue_empty",   64'(q1.size()),     64'd0);
        chk("s4_queue_empty",   64'(q4.size()),     64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
